conv_window_gen: RTL and testbench

//  Streaming sliding-window generator that sits directly upstream of the convolution unit.

---
 rtl/conv_pkg.sv | 28 ++
 rtl/conv_window_gen_line_shift_reg.sv | 34 +++
 rtl/conv_window_gen.sv | 152 +++++++++++++++
 tb/tb_conv_window_gen.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants and index helpers for the convolution sliding-window generator.
package conv_pkg;

    localparam int CONV_DATA_WIDTH = 16;

    typedef logic [CONV_DATA_WIDTH-1:0] halfPixel_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic int win_idx(input int r, input int c, input int f);
        return r * f + c;
    endfunction

    // Distance back from the newest pixel in the delay line for a pixel r rows and c columns earlier.
    function automatic int tap_offset(input int r, input int c, input int imgW);
        return r * imgW + c;
    endfunction

endpackage

// File: rtl/conv_window_gen_line_shift_reg.sv
// Enable-gated pixel delay line; taps_o shows the contents as they will be after this cycle's shift.
module line_shift_reg #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        shift_en_i,
    input  logic [DATA_WIDTH-1:0]       data_i,
    output logic [DEPTH*DATA_WIDTH-1:0] taps_o
);

    logic [DEPTH*DATA_WIDTH-1:0] lineQ;
    logic [DEPTH*DATA_WIDTH-1:0] lineD;

    // Entry 0 is the newest pixel, so the window logic sees the incoming pixel in the same cycle.
    always_comb begin
        lineD = lineQ;
        if (shift_en_i) begin
            lineD = {lineQ[(DEPTH-1)*DATA_WIDTH-1:0], data_i};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lineQ <= '0;
        end else begin
            lineQ <= lineD;
        end
    end

    assign taps_o = lineD;

endmodule

// File: rtl/conv_window_gen.sv
// Streaming FxF stride-1 window generator feeding the convolution unit.
// Optional port win_last is built when CONV_WIN_LAST_EN is defined.
module conv_window_gen
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = CONV_DATA_WIDTH,
    parameter int F          = 5,
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_WIDTH-1:0]         pix_in,
    input  logic                          pix_valid,
    output logic                          pix_ready,
    output logic [0:F*F*DATA_WIDTH-1]     win_data,
    output logic                          win_valid,
    input  logic                          win_ready,
    output logic [clog2(IMG_H)-1:0]       win_row,
    output logic [clog2(IMG_W)-1:0]       win_col,
`ifdef CONV_WIN_LAST_EN
    output logic                          win_last,
`endif
    output logic                          frame_done
);

    localparam int ROW_W    = clog2(IMG_H);
    localparam int COL_W    = clog2(IMG_W);
    localparam int DEPTH    = (F - 1) * IMG_W + F;
    localparam int WIN_BITS = F * F * DATA_WIDTH;

    localparam logic [ROW_W-1:0] RowFirst = ROW_W'(F - 1);
    localparam logic [ROW_W-1:0] RowLast  = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] ColFirst = COL_W'(F - 1);
    localparam logic [COL_W-1:0] ColLast  = COL_W'(IMG_W - 1);

    logic [COL_W-1:0]            colQ, colD;
    logic [ROW_W-1:0]            rowQ, rowD;
    logic                        frameDoneQ, frameDoneD;
    logic [0:WIN_BITS-1]         winDataQ, winDataD;
    logic                        winValidQ, winValidD;
    logic [ROW_W-1:0]            winRowQ, winRowD;
    logic [COL_W-1:0]            winColQ, winColD;
    logic [DEPTH*DATA_WIDTH-1:0] taps;
    logic                        accept;
    logic                        lastCol;
    logic                        lastRow;
    logic                        loadWin;
    logic                        unusedtaps;

    assign pix_ready = !reset && (!winValidQ || win_ready);
    assign accept    = pix_valid && pix_ready;
    assign lastCol   = (colQ == ColLast);
    assign lastRow   = (rowQ == RowLast);
    assign loadWin   = accept && (rowQ >= RowFirst) && (colQ >= ColFirst);

    line_shift_reg #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH)
    ) uDelayLine (
        .clk       (clk),
        .reset     (reset),
        .shift_en_i(accept),
        .data_i    (pix_in),
        .taps_o    (taps)
    );

    // Only the taps inside the window footprint are used; the rest just carry pixels down the line.
    assign unusedtaps = ^taps;

    always_comb begin
        colD       = colQ;
        rowD       = rowQ;
        frameDoneD = 1'b0;
        if (accept) begin
            if (lastCol) begin
                colD       = '0;
                rowD       = lastRow ? '0 : rowQ + 1'b1;
                frameDoneD = lastRow;
            end else begin
                colD = colQ + 1'b1;
            end
        end
    end

    // A window is only built once the full footprint lies in the current frame, so no stale pixels leak in.
    always_comb begin
        winDataD  = winDataQ;
        winValidD = winValidQ && !win_ready;
        winRowD   = winRowQ;
        winColD   = winColQ;
        if (loadWin) begin
            winValidD = 1'b1;
            winRowD   = rowQ - RowFirst;
            winColD   = colQ - ColFirst;
            for (int r = 0; r < F; r++) begin
                for (int c = 0; c < F; c++) begin
                    winDataD[win_idx(r, c, F)*DATA_WIDTH +: DATA_WIDTH] =
                        taps[tap_offset(F-1-r, F-1-c, IMG_W)*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            colQ       <= '0;
            rowQ       <= '0;
            frameDoneQ <= 1'b0;
            winDataQ   <= '0;
            winValidQ  <= 1'b0;
            winRowQ    <= '0;
            winColQ    <= '0;
        end else begin
            colQ       <= colD;
            rowQ       <= rowD;
            frameDoneQ <= frameDoneD;
            winDataQ   <= winDataD;
            winValidQ  <= winValidD;
            winRowQ    <= winRowD;
            winColQ    <= winColD;
        end
    end

    assign win_data   = winDataQ;
    assign win_valid  = winValidQ;
    assign win_row    = winRowQ;
    assign win_col    = winColQ;
    assign frame_done = frameDoneQ;

`ifdef CONV_WIN_LAST_EN
    logic winLastQ, winLastD;

    always_comb begin
        winLastD = winLastQ;
        if (loadWin) begin
            winLastD = lastRow && lastCol;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            winLastQ <= 1'b0;
        end else begin
            winLastQ <= winLastD;
        end
    end

    assign win_last = winLastQ;
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
// Self-checking bench for conv_window_gen at F=3 on a 4x4 image; checks win_last when CONV_WIN_LAST_EN is defined.
module tb_conv_window_gen;

    localparam int DW       = 16;
    localparam int F        = 3;
    localparam int W        = 4;
    localparam int H        = 4;
    localparam int WinBits  = F * F * DW;

    typedef struct {
        int row;
        int col;
        int pix[9];
    } winRec_t;

    logic                clk = 1'b0;
    logic                reset;
    logic [DW-1:0]       pix_in;
    logic                pix_valid;
    logic                pix_ready;
    logic [0:WinBits-1]  win_data;
    logic                win_valid;
    logic                win_ready;
    logic [1:0]          win_row;
    logic [1:0]          win_col;
    logic                frame_done;
`ifdef CONV_WIN_LAST_EN
    logic                win_last;
`endif

    int      tests = 0;
    int      failures = 0;
    int      readyMode = 0;
    int      frameDoneCnt = 0;
    int      startDone;
    int      waited;
    winRec_t expQ[$];
    winRec_t vecTable[4];
    winRec_t monExp;

    always #5 clk = ~clk;

    conv_window_gen #(
        .DATA_WIDTH(DW),
        .F         (F),
        .IMG_W     (W),
        .IMG_H     (H)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pix_in    (pix_in),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .win_data  (win_data),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .win_row   (win_row),
        .win_col   (win_col),
`ifdef CONV_WIN_LAST_EN
        .win_last  (win_last),
`endif
        .frame_done(frame_done)
    );

    function automatic logic [0:WinBits-1] packWin(input winRec_t w);
        logic [0:WinBits-1] v;
        v = '0;
        for (int k = 0; k < F * F; k++) begin
            v[k*DW +: DW] = DW'(w.pix[k]);
        end
        return v;
    endfunction

    function automatic winRec_t modelWin(input int base, input int r, input int c);
        winRec_t w;
        w.row = r;
        w.col = c;
        for (int k = 0; k < F * F; k++) begin
            w.pix[k] = base + (r + k / F) * W + (c + k % F);
        end
        return w;
    endfunction

    task automatic checkOutput(input string name, input logic [WinBits-1:0] act, input logic [WinBits-1:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drives nPix raster pixels starting at value base, optionally pushing model windows for them first.
    task automatic applyStimulus(input int base, input int nPix, input int gapPct, input bit pushModel);
        bit accepted;
        int waitCnt;
        if (pushModel) begin
            for (int r = 0; r <= H - F; r++) begin
                for (int c = 0; c <= W - F; c++) begin
                    if ((r + F - 1) * W + (c + F - 1) < nPix) begin
                        expQ.push_back(modelWin(base, r, c));
                    end
                end
            end
        end
        for (int idx = 0; idx < nPix; idx++) begin
            while (gapPct > 0 && $urandom_range(0, 99) < gapPct) begin
                pix_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            pix_in    = DW'(base + idx);
            pix_valid = 1'b1;
            accepted  = 1'b0;
            waitCnt   = 0;
            while (!accepted && waitCnt < 200) begin
                @(negedge clk);
                accepted = pix_ready;
                @(posedge clk);
                #1;
                waitCnt++;
            end
            if (!accepted) begin
                tests++;
                failures++;
                $display("[TB] FAIL acceptTimeout: pixel %0d not accepted, expected acceptance within 200 cycles", idx);
            end
        end
        pix_valid = 1'b0;
    endtask

    task automatic drainQueue();
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        checkOutput("queueDrained", WinBits'(expQ.size()), '0);
    endtask

    initial begin
        win_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0:       win_ready = 1'b1;
                1:       win_ready = 1'($urandom_range(0, 1));
                default: win_ready = 1'b0;
            endcase
        end
    end

    // Consumer side: every window handed over is checked against the oldest expected entry.
    always @(negedge clk) begin
        if (!reset && frame_done) begin
            frameDoneCnt++;
        end
        if (!reset && win_valid && win_ready) begin
            if (expQ.size() == 0) begin
                tests++;
                failures++;
                $display("[TB] FAIL unexpectedWindow: got window (%0d,%0d), expected none", win_row, win_col);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("winData", win_data, packWin(monExp));
                checkOutput("winRow", WinBits'(win_row), WinBits'(monExp.row));
                checkOutput("winCol", WinBits'(win_col), WinBits'(monExp.col));
`ifdef CONV_WIN_LAST_EN
                checkOutput("winLast", WinBits'(win_last), WinBits'(monExp.row == 1 && monExp.col == 1));
`endif
            end
        end
    end

    initial begin
        vecTable[0] = '{0, 0, '{0, 1, 2, 4, 5, 6, 8, 9, 10}};
        vecTable[1] = '{0, 1, '{1, 2, 3, 5, 6, 7, 9, 10, 11}};
        vecTable[2] = '{1, 0, '{4, 5, 6, 8, 9, 10, 12, 13, 14}};
        vecTable[3] = '{1, 1, '{5, 6, 7, 9, 10, 11, 13, 14, 15}};

        reset     = 1'b1;
        pix_valid = 1'b0;
        pix_in    = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("resetWinValid", WinBits'(win_valid), '0);
        checkOutput("resetPixReady", WinBits'(pix_ready), '0);
        checkOutput("resetWinData", win_data, '0);
        checkOutput("resetFrameDone", WinBits'(frame_done), '0);
        reset = 1'b0;
        #1;
        checkOutput("releasePixReady", WinBits'(pix_ready), WinBits'(1));
        @(posedge clk);
        #1;

        // Single frame, consumer always ready, expectations straight from the table.
        for (int i = 0; i < 4; i++) begin
            expQ.push_back(vecTable[i]);
        end
        startDone = frameDoneCnt;
        applyStimulus(0, W * H, 0, 1'b0);
        drainQueue();
        checkOutput("frameDoneOnce", WinBits'(frameDoneCnt - startDone), WinBits'(1));

        // Consumer stalls on the first window: input must stop and the window must hold.
        readyMode = 2;
        @(posedge clk);
        #1;
        fork
            applyStimulus(0, W * H, 0, 1'b1);
            begin
                waited = 0;
                while (!win_valid && waited < 300) begin
                    @(negedge clk);
                    waited++;
                end
                checkOutput("stallSeen", WinBits'(win_valid), WinBits'(1));
                repeat (4) begin
                    @(negedge clk);
                    checkOutput("stallPixReady", WinBits'(pix_ready), '0);
                    checkOutput("stallWinData", win_data, packWin(vecTable[0]));
                end
                readyMode = 0;
            end
        join
        drainQueue();

        // Two frames back to back with distinct pixel values.
        startDone = frameDoneCnt;
        applyStimulus(0, W * H, 0, 1'b1);
        applyStimulus(100, W * H, 0, 1'b1);
        drainQueue();
        checkOutput("frameDoneTwice", WinBits'(frameDoneCnt - startDone), WinBits'(2));

        // Reset in the middle of a frame, then a clean restart.
        applyStimulus(0, 8, 0, 1'b1);
        reset = 1'b1;
        #1;
        checkOutput("midResetWinValid", WinBits'(win_valid), '0);
        checkOutput("midResetWinData", win_data, '0);
        checkOutput("midResetWinRow", WinBits'(win_row), '0);
        checkOutput("midResetWinCol", WinBits'(win_col), '0);
        checkOutput("midResetPixReady", WinBits'(pix_ready), '0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            expQ.push_back(vecTable[i]);
        end
        applyStimulus(0, W * H, 0, 1'b0);
        drainQueue();

        // Random input gaps and random consumer readiness.
        readyMode = 1;
        startDone = frameDoneCnt;
        for (int i = 0; i < 4; i++) begin
            expQ.push_back(vecTable[i]);
        end
        applyStimulus(0, W * H, 50, 1'b0);
        drainQueue();
        readyMode = 0;
        checkOutput("frameDoneRandom", WinBits'(frameDoneCnt - startDone), WinBits'(1));

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
